// File: rtl/deser_demux_pkg.sv
// Shared constants and sizing helpers for the serial-to-parallel demultiplexer.
package deser_demux_pkg;
  localparam int DEF_NLANES = 16;
  localparam int DEF_WIDTH  = 1;
  localparam int CNT_W      = 16;

  // Lane pointer width; a single-lane build still needs a 1-bit pointer.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/deser_demux_lane_counter.sv
// Modulo-NLANES lane pointer; hold freezes it regardless of adv, wrap flags the last-lane step.
module lane_counter #(
  parameter int NLANES = 16,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             hold,
  output logic [IDX_W-1:0] idx,
  output logic             wrap
);
  logic             w_step;
  logic             w_last;
  logic [IDX_W-1:0] r_idx;

  assign w_step = adv & ~hold;
  assign w_last = (r_idx == IDX_W'(NLANES - 1));
  assign wrap   = w_step & w_last;
  assign idx    = r_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_idx <= '0;
    else if (w_step) r_idx <= w_last ? '0 : r_idx + 1'b1;
  end
endmodule

// File: rtl/deser_demux.sv
// 1:Nlanes deserializer: fills shadow lanes in order and publishes a registered word
// with a one-cycle strobe when the last lane's sample arrives.
module deser_demux
  import deser_demux_pkg::*;
#(
  parameter int Nlanes = DEF_NLANES,
  parameter int Width  = DEF_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [Width-1:0]               in,
  input  logic                           in_valid,
  input  logic                           slip,
  output logic [Nlanes*Width-1:0]        out,
  output logic                           out_valid,
  output logic [idx_width(Nlanes)-1:0]   lane_idx,
  output logic [CNT_W-1:0]               word_cnt
);
  localparam int IDX_W = idx_width(Nlanes);

  logic                               w_accept;
  logic                               w_wrap;
  logic [IDX_W-1:0]                   w_idx;
  logic [Nlanes-1:0][Width-1:0]       w_word;
  logic [Nlanes-1:0][Width-1:0]       r_out;
  logic                               r_valid;
  logic [CNT_W-1:0]                   r_cnt;

  assign w_accept = in_valid & ~slip;

  lane_counter #(.NLANES(Nlanes), .IDX_W(IDX_W)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .adv  (in_valid),
    .hold (slip),
    .idx  (w_idx),
    .wrap (w_wrap)
  );

  // The last lane is never stored: it comes straight from in on the completing cycle.
  for (genvar k = 0; k < Nlanes; k++) begin : g_lane
    if (k == Nlanes - 1) begin : g_top
      assign w_word[k] = in;
    end else begin : g_shadow
      logic [Width-1:0] r_lane;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  r_lane <= '0;
        else if (w_accept && w_idx == IDX_W'(k))  r_lane <= in;
      end
      assign w_word[k] = r_lane;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_valid <= w_wrap;
      if (w_wrap) begin
        r_out <= w_word;
        if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_valid;
  assign lane_idx  = w_idx;
  assign word_cnt  = r_cnt;
endmodule

// File: tb/tb_deser_demux.sv
// Bench for deser_demux: vector table and hand sequences on a 4x4 build, queue-model
// random traffic, and a 1x8 build for back-to-back words and counter saturation.
module tb_deser_demux;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  a_in;
  logic        a_v, a_s;
  logic [15:0] a_out;
  logic        a_ov;
  logic [1:0]  a_idx;
  logic [15:0] a_cnt;

  logic [7:0]  b_in;
  logic        b_v, b_s;
  logic [7:0]  b_out;
  logic        b_ov;
  logic [0:0]  b_idx;
  logic [15:0] b_cnt;

  deser_demux #(.Nlanes(4), .Width(4)) dut_a (
    .clk(clk), .rst(rst), .in(a_in), .in_valid(a_v), .slip(a_s),
    .out(a_out), .out_valid(a_ov), .lane_idx(a_idx), .word_cnt(a_cnt));

  deser_demux #(.Nlanes(1), .Width(8)) dut_b (
    .clk(clk), .rst(rst), .in(b_in), .in_valid(b_v), .slip(b_s),
    .out(b_out), .out_valid(b_ov), .lane_idx(b_idx), .word_cnt(b_cnt));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  din;
    logic        v;
    logic        s;
    logic [15:0] eo;
    logic        ev;
    logic [1:0]  ei;
    logic [15:0] ec;
  } vec_t;

  vec_t vecs[40];
  int   nv = 0;

  task automatic add(input logic [3:0] d, input logic v, input logic s,
                     input logic [15:0] eo, input logic ev, input logic [1:0] ei,
                     input logic [15:0] ec);
    vecs[nv] = '{d, v, s, eo, ev, ei, ec};
    nv++;
  endtask

  task automatic a_step(input logic [3:0] d, input logic v, input logic s);
    a_in = d; a_v = v; a_s = s;
    @(posedge clk); #1;
  endtask

  task automatic b_step(input logic [7:0] d, input logic v);
    b_in = d; b_v = v; b_s = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic chk_a(input string nm, input logic [15:0] eo, input logic ev,
                       input logic [1:0] ei, input logic [15:0] ec);
    chk({nm, ".out"}, 64'(a_out), 64'(eo));
    chk({nm, ".out_valid"}, 64'(a_ov), 64'(ev));
    chk({nm, ".lane_idx"}, 64'(a_idx), 64'(ei));
    chk({nm, ".word_cnt"}, 64'(a_cnt), 64'(ec));
  endtask

  // Reference model state: accepted samples of the word in progress.
  logic [3:0]  q[$];
  logic [15:0] m_out;
  logic        m_v;
  logic [15:0] m_cnt;

  initial begin
    rst = 1'b1;
    a_in = '0; a_v = 1'b0; a_s = 1'b0;
    b_in = '0; b_v = 1'b0; b_s = 1'b0;
    #1;
    chk_a("reset", 16'h0, 1'b0, 2'd0, 16'd0);
    chk("reset.b_out", 64'(b_out), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // fill
    add(4'h1,1,0, 16'h0000,0,1,0);
    add(4'h2,1,0, 16'h0000,0,2,0);
    add(4'h3,1,0, 16'h0000,0,3,0);
    add(4'h4,1,0, 16'h4321,1,0,1);
    add(4'h0,0,0, 16'h4321,0,0,1);
    // gapped
    add(4'h1,1,0, 16'h4321,0,1,1);
    add(4'h7,0,0, 16'h4321,0,1,1);
    add(4'h2,1,0, 16'h4321,0,2,1);
    add(4'h7,0,0, 16'h4321,0,2,1);
    add(4'h3,1,0, 16'h4321,0,3,1);
    add(4'h7,0,0, 16'h4321,0,3,1);
    add(4'h4,1,0, 16'h4321,1,0,2);
    add(4'h0,0,0, 16'h4321,0,0,2);
    // slip on first sample
    add(4'hA,1,1, 16'h4321,0,0,2);
    add(4'hB,1,0, 16'h4321,0,1,2);
    add(4'hC,1,0, 16'h4321,0,2,2);
    add(4'hD,1,0, 16'h4321,0,3,2);
    add(4'hE,1,0, 16'hEDCB,1,0,3);
    // slip at the last lane suppresses completion; slip without valid is inert
    add(4'h1,1,0, 16'hEDCB,0,1,3);
    add(4'h2,1,0, 16'hEDCB,0,2,3);
    add(4'h3,1,0, 16'hEDCB,0,3,3);
    add(4'h9,1,1, 16'hEDCB,0,3,3);
    add(4'h9,0,1, 16'hEDCB,0,3,3);
    add(4'h4,1,0, 16'h4321,1,0,4);

    for (int i = 0; i < nv; i++) begin
      a_step(vecs[i].din, vecs[i].v, vecs[i].s);
      chk_a($sformatf("vec%0d", i), vecs[i].eo, vecs[i].ev, vecs[i].ei, vecs[i].ec);
    end

    // mid-word asynchronous reset
    a_step(4'h1, 1, 0);
    a_step(4'h2, 1, 0);
    chk("midrst.pre_idx", 64'(a_idx), 64'd2);
    a_v = 1'b0;
    #2 rst = 1'b1;
    #1 chk_a("midrst.async", 16'h0, 1'b0, 2'd0, 16'd0);
    #1 rst = 1'b0;
    a_step(4'h5, 1, 0);
    a_step(4'h6, 1, 0);
    a_step(4'h7, 1, 0);
    a_step(4'h8, 1, 0);
    chk_a("midrst.word", 16'h8765, 1'b1, 2'd0, 16'd1);
    a_step(4'h0, 0, 0);

    // randomized traffic against the queue model
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    q.delete(); m_out = '0; m_v = 1'b0; m_cnt = '0;
    for (int i = 0; i < 400; i++) begin
      logic [3:0] d;
      logic v, s;
      d = 4'($urandom);
      v = ($urandom_range(0, 9) < 7);
      s = ($urandom_range(0, 9) < 2);
      m_v = 1'b0;
      if (v && !s) begin
        q.push_back(d);
        if (q.size() == 4) begin
          m_out = {q[3], q[2], q[1], q[0]};
          m_v   = 1'b1;
          q.delete();
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
      end
      a_step(d, v, s);
      chk_a($sformatf("rnd%0d", i), m_out, m_v, 2'(q.size()), m_cnt);
    end
    a_v = 1'b0; a_s = 1'b0;

    // single lane: every accepted sample is a word
    b_step(8'h11, 1);
    chk("n1.out0", 64'(b_out), 64'h11); chk("n1.v0", 64'(b_ov), 64'd1);
    chk("n1.cnt0", 64'(b_cnt), 64'd1);
    b_step(8'h22, 1);
    chk("n1.out1", 64'(b_out), 64'h22); chk("n1.v1", 64'(b_ov), 64'd1);
    chk("n1.cnt1", 64'(b_cnt), 64'd2);
    b_step(8'h33, 1);
    chk("n1.out2", 64'(b_out), 64'h33); chk("n1.v2", 64'(b_ov), 64'd1);
    chk("n1.cnt2", 64'(b_cnt), 64'd3);
    chk("n1.idx", 64'(b_idx), 64'd0);

    // saturation: bring the count to 16'hFFFF, then keep completing words
    for (int i = 3; i < 65535; i++) b_step(8'(i), 1);
    chk("sat.reach", 64'(b_cnt), 64'hFFFF);
    b_step(8'hA5, 1);
    chk("sat.hold", 64'(b_cnt), 64'hFFFF);
    chk("sat.v", 64'(b_ov), 64'd1);
    chk("sat.out", 64'(b_out), 64'hA5);
    b_step(8'h00, 0);
    chk("sat.idle_v", 64'(b_ov), 64'd0);
    chk("sat.idle_out", 64'(b_out), 64'hA5);
    b_step(8'h5A, 1);
    chk("sat.v2", 64'(b_ov), 64'd1);
    chk("sat.out2", 64'(b_out), 64'h5A);
    chk("sat.hold2", 64'(b_cnt), 64'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
